// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: reset vector and nop encoding.
package fetch_stage_pkg;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_inst_holdbuf.sv
// Hold buffer for SRAM read data: keeps the fetched word alive while ID stalls,
// because the SRAM data is only valid for the one cycle after its enable.
module inst_holdbuf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        hold,
    input  logic [31:0] rdata,
    output logic [31:0] inst_out
);

    logic        buf_valid_q;
    logic [31:0] inst_buf_q;

    // Capture on the first stall cycle, release when the instruction moves to ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            inst_buf_q  <= NOP_INST;
        end else if (valid && hold && !buf_valid_q) begin
            buf_valid_q <= 1'b1;
            inst_buf_q  <= rdata;
        end else if (valid && !hold) begin
            buf_valid_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_q;
        end
    end

    assign inst_out = buf_valid_q ? inst_buf_q : rdata;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, drives the 1-cycle instruction SRAM and hands
// instructions to ID over valid/allowin. Optional macro: FETCH_ADDREXC_EN.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_allowin_in,
    input  logic [31:0] id_nextPC_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic [31:0] if_NPC_fast_wire,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_addrexc_out
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic        allowin_s;
    logic [31:0] inst_s;

    assign allowin_s      = !valid_q || id_allowin_in;
    assign inst_sram_en   = allowin_s && rst_n;
    assign inst_sram_addr = valid_q ? id_nextPC_in : RESET_PC;

    // Fetch PC advances whenever a new SRAM read is issued; valid never drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
        end else if (allowin_s) begin
            valid_q <= 1'b1;
            pc_q    <= inst_sram_addr;
        end else begin
            valid_q <= valid_q;
            pc_q    <= pc_q;
        end
    end

    inst_holdbuf u_holdbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid_q),
        .hold     (!id_allowin_in),
        .rdata    (inst_sram_rdata),
        .inst_out (inst_s)
    );

    assign if_valid_out     = valid_q;
    assign if_PC_out        = pc_q;
    assign if_NPC_out       = pc_q + 32'd4;
    assign if_NNPC_out      = pc_q + 32'd8;
    assign if_NPC_fast_wire = pc_q + 32'd4;

`ifdef FETCH_ADDREXC_EN
    // Misaligned fetch still reads the SRAM, but ID sees a nop plus the flag
    assign if_addrexc_out  = valid_q && (pc_q[1:0] != 2'b00);
    assign if_Instruct_out = if_addrexc_out ? NOP_INST : inst_s;
`else
    assign if_addrexc_out  = 1'b0;
    assign if_Instruct_out = inst_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; outputs sampled on the falling edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_allowin_in;
    logic [31:0] id_nextPC_in;
    logic        if_valid_out;
    logic [31:0] if_PC_out;
    logic [31:0] if_NPC_out;
    logic [31:0] if_NNPC_out;
    logic [31:0] if_Instruct_out;
    logic [31:0] if_NPC_fast_wire;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        if_addrexc_out;

    int errors = 0;
    int checks = 0;
    logic junk_mode = 1'b0;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_allowin_in    (id_allowin_in),
        .id_nextPC_in     (id_nextPC_in),
        .if_valid_out     (if_valid_out),
        .if_PC_out        (if_PC_out),
        .if_NPC_out       (if_NPC_out),
        .if_NNPC_out      (if_NNPC_out),
        .if_Instruct_out  (if_Instruct_out),
        .if_NPC_fast_wire (if_NPC_fast_wire),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_rdata  (inst_sram_rdata),
        .if_addrexc_out   (if_addrexc_out)
    );

    always #5 clk = ~clk;

    // SRAM model: data = addr ^ A5A5A5A5 one cycle after enable; junk when idle
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_sram_addr ^ 32'hA5A5_A5A5;
        else if (junk_mode)
            inst_sram_rdata <= 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_allowin_in = 1'b1;
        id_nextPC_in = 32'h0000_0000;
        junk_mode = 1'b0;
        step();
        step();
    endtask

    // Release reset and run until IF presents stop_pc (sequential fetch)
    task automatic run_to(input logic [31:0] stop_pc);
        logic [31:0] pc;
        rst_n = 1'b1;
        id_allowin_in = 1'b1;
        pc = 32'hBFC0_0000;
        step();
        while (if_PC_out !== stop_pc && pc != stop_pc) begin
            id_nextPC_in = pc + 32'd4;
            pc = pc + 32'd4;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_valid_out); end
        checks++; if (if_PC_out !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc got=%h exp=bfc00000", if_PC_out); end
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
        checks++; if (if_addrexc_out !== 1'b0) begin errors++; $display("FAIL reset_addrexc got=%b exp=0", if_addrexc_out); end
    endtask

    task automatic test_sequential_and_stall();
        logic [31:0] exp_pc;
        do_reset();
        rst_n = 1'b1;
        #1;
        checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL first_issue en=%b addr=%h exp en=1 addr=bfc00000", inst_sram_en, inst_sram_addr); end
        step();
        for (int k = 0; k < 5; k++) begin
            exp_pc = 32'hBFC0_0000 + 32'(4 * k);
            checks++; if (if_valid_out !== 1'b1 || if_PC_out !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] valid=%b pc=%h exp pc=%h", k, if_valid_out, if_PC_out, exp_pc); end
            checks++; if (if_Instruct_out !== (exp_pc ^ 32'hA5A5_A5A5)) begin errors++; $display("FAIL seq_inst[%0d] got=%h exp=%h", k, if_Instruct_out, exp_pc ^ 32'hA5A5_A5A5); end
            if (k < 4) begin
                id_nextPC_in = exp_pc + 32'd4;
                #1;
                checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_addr[%0d] en=%b addr=%h exp=%h", k, inst_sram_en, inst_sram_addr, exp_pc + 32'd4); end
                step();
            end
        end
        // PC BFC00010 now presented; stall three cycles with junk SRAM data
        id_allowin_in = 1'b0;
        id_nextPC_in = 32'h1234_5678;
        junk_mode = 1'b1;
        #1;
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL stall_en0 got=%b exp=0", inst_sram_en); end
        for (int s = 0; s < 3; s++) begin
            step();
            checks++; if (if_Instruct_out !== 32'h1A65_A5B5) begin errors++; $display("FAIL stall_inst[%0d] got=%h exp=1a65a5b5", s, if_Instruct_out); end
            checks++; if (inst_sram_en !== 1'b0 || if_PC_out !== 32'hBFC0_0010) begin errors++; $display("FAIL stall_hold[%0d] en=%b pc=%h exp en=0 pc=bfc00010", s, inst_sram_en, if_PC_out); end
            checks++; if (if_NNPC_out !== 32'hBFC0_0018) begin errors++; $display("FAIL stall_nnpc[%0d] got=%h exp=bfc00018", s, if_NNPC_out); end
        end
        // Release: transfer and issue in the same cycle, no bubble
        id_allowin_in = 1'b1;
        id_nextPC_in = 32'hBFC0_0014;
        #1;
        checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL release_issue en=%b addr=%h exp en=1 addr=bfc00014", inst_sram_en, inst_sram_addr); end
        step();
        checks++; if (if_PC_out !== 32'hBFC0_0014 || if_Instruct_out !== 32'h1A65_A5B1) begin errors++; $display("FAIL release_next pc=%h inst=%h exp pc=bfc00014 inst=1a65a5b1", if_PC_out, if_Instruct_out); end
        // Reset during a buffered stall
        id_allowin_in = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++; if (if_valid_out !== 1'b0 || if_PC_out !== 32'hBFC0_0000) begin errors++; $display("FAIL rststall_state valid=%b pc=%h exp valid=0 pc=bfc00000", if_valid_out, if_PC_out); end
        checks++; if (if_Instruct_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rststall_buf got=%h exp=deadbeef", if_Instruct_out); end
        rst_n = 1'b1;
        #1;
        checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL restart_issue en=%b addr=%h exp en=1 addr=bfc00000", inst_sram_en, inst_sram_addr); end
        step();
        checks++; if (if_valid_out !== 1'b1 || if_Instruct_out !== 32'h1A65_A5A5) begin errors++; $display("FAIL restart_inst valid=%b inst=%h exp valid=1 inst=1a65a5a5", if_valid_out, if_Instruct_out); end
    endtask

    task automatic test_branch();
        do_reset();
        run_to(32'hBFC0_0008);
        checks++; if (if_PC_out !== 32'hBFC0_0008) begin errors++; $display("FAIL branch_setup pc=%h exp=bfc00008", if_PC_out); end
        id_nextPC_in = 32'hBFC0_0100;
        step();
        checks++; if (if_PC_out !== 32'hBFC0_0100 || if_NPC_fast_wire !== 32'hBFC0_0104) begin errors++; $display("FAIL branch_target pc=%h fast=%h exp pc=bfc00100 fast=bfc00104", if_PC_out, if_NPC_fast_wire); end
        checks++; if (if_Instruct_out !== 32'h1A65_A4A5) begin errors++; $display("FAIL branch_inst got=%h exp=1a65a4a5", if_Instruct_out); end
    endtask

    task automatic test_wrap();
        id_nextPC_in = 32'hFFFF_FFFC;
        step();
        checks++; if (if_PC_out !== 32'hFFFF_FFFC || if_NPC_out !== 32'h0000_0000 || if_NNPC_out !== 32'h0000_0004) begin errors++; $display("FAIL wrap pc=%h npc=%h nnpc=%h exp fffffffc/00000000/00000004", if_PC_out, if_NPC_out, if_NNPC_out); end
        checks++; if (if_NPC_fast_wire !== 32'h0000_0000) begin errors++; $display("FAIL wrap_fast got=%h exp=00000000", if_NPC_fast_wire); end
    endtask

    task automatic test_addrexc();
        id_nextPC_in = 32'hBFC0_0102;
        step();
        checks++; if (if_PC_out !== 32'hBFC0_0102) begin errors++; $display("FAIL misalign_pc got=%h exp=bfc00102", if_PC_out); end
`ifdef FETCH_ADDREXC_EN
        checks++; if (if_addrexc_out !== 1'b1 || if_Instruct_out !== 32'h0000_0000) begin errors++; $display("FAIL addrexc flag=%b inst=%h exp flag=1 inst=00000000", if_addrexc_out, if_Instruct_out); end
`else
        checks++; if (if_addrexc_out !== 1'b0 || if_Instruct_out !== 32'h1A65_A4A7) begin errors++; $display("FAIL addrexc flag=%b inst=%h exp flag=0 inst=1a65a4a7", if_addrexc_out, if_Instruct_out); end
`endif
        id_nextPC_in = 32'hBFC0_0104;
        step();
        checks++; if (if_addrexc_out !== 1'b0 || if_Instruct_out !== 32'h1A65_A4A1) begin errors++; $display("FAIL aligned_after flag=%b inst=%h exp flag=0 inst=1a65a4a1", if_addrexc_out, if_Instruct_out); end
    endtask

    initial begin
        inst_sram_rdata = 32'h0000_0000;
        test_reset();
        test_sequential_and_stall();
        test_branch();
        test_wrap();
        test_addrexc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
